// File: rtl/sprite_line_fetcher.sv
// sprite_line_fetcher
//   Per-scanline sprite scheduler. It holds a table of NSLOT sprite slots.
//   On a start pulse it walks the slots in ascending order. For each slot that
//   covers the requested line, it reads one 16-pixel sprite row from the
//   registered sprite ROM and writes the opaque pixels into the line buffer.
//   Because slots are walked in ascending order, higher slot indices land on top.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   cfg_we/cfg_slot/...  slot table write (x, y, sprite id, enable)
//   start, line_y        begin fetching for line_y (accepted only when idle)
//   busy, done           activity flag / one-cycle completion pulse
//   rom_addr, rom_pixel  sprite ROM port ({id,row,col}); data one cycle later
//   lb_we/lb_addr/lb_data line buffer write port
module sprite_line_fetcher #(
    parameter int NSLOT    = 4,
    parameter int H_ACTIVE = 640
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     cfg_we,
    input  logic [$clog2(NSLOT)-1:0] cfg_slot,
    input  logic [9:0]               cfg_x,
    input  logic [9:0]               cfg_y,
    input  logic [3:0]               cfg_id,
    input  logic                     cfg_en,
    input  logic                     start,
    input  logic [9:0]               line_y,
    output logic                     busy,
    output logic                     done,
    output logic [11:0]              rom_addr,
    input  logic [3:0]               rom_pixel,
    output logic                     lb_we,
    output logic [9:0]               lb_addr,
    output logic [3:0]               lb_data
);
    localparam int SW = $clog2(NSLOT);

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_FETCH, S_DRAIN, S_DONE} state_t;

    // ---------------- slot table ----------------
    logic [9:0] slot_x  [NSLOT];
    logic [9:0] slot_y  [NSLOT];
    logic [3:0] slot_id [NSLOT];
    logic       slot_en [NSLOT];

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            logic [9:0] x_reg;
            logic [9:0] y_reg;
            logic [3:0] id_reg;
            logic       en_reg;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    x_reg  <= '0;
                    y_reg  <= '0;
                    id_reg <= '0;
                    en_reg <= 1'b0;
                end else if (cfg_we && (cfg_slot == SW'(gi))) begin
                    x_reg  <= cfg_x;
                    y_reg  <= cfg_y;
                    id_reg <= cfg_id;
                    en_reg <= cfg_en;
                end
            end

            assign slot_x[gi]  = x_reg;
            assign slot_y[gi]  = y_reg;
            assign slot_id[gi] = id_reg;
            assign slot_en[gi] = en_reg;
        end
    endgenerate

    // ---------------- sequencer state ----------------
    state_t        state_reg, state_next;
    logic [SW-1:0] s_reg, s_next;
    logic [9:0]    line_reg, line_next;
    logic [3:0]    col_reg, col_next;
    // Working copy of the slot being fetched, so config writes cannot disturb it.
    logic [9:0]    wx_reg, wx_next;
    logic [3:0]    wid_reg, wid_next;
    logic [3:0]    wrow_reg, wrow_next;
    // One-cycle delay that lines the column up with the registered ROM data.
    logic          valid_d_reg, valid_d_next;
    logic [3:0]    col_d_reg, col_d_next;

    logic [9:0]    scan_row;
    logic          scan_vis;
    logic          last_slot;

    // Rows above the sprite wrap to large values and fail the < 16 test.
    assign scan_row  = line_reg - slot_y[s_reg];
    assign scan_vis  = slot_en[s_reg] && (scan_row < 10'd16);
    assign last_slot = (s_reg == {SW{1'b1}});

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= S_IDLE;
            s_reg       <= '0;
            line_reg    <= '0;
            col_reg     <= '0;
            wx_reg      <= '0;
            wid_reg     <= '0;
            wrow_reg    <= '0;
            valid_d_reg <= 1'b0;
            col_d_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            s_reg       <= s_next;
            line_reg    <= line_next;
            col_reg     <= col_next;
            wx_reg      <= wx_next;
            wid_reg     <= wid_next;
            wrow_reg    <= wrow_next;
            valid_d_reg <= valid_d_next;
            col_d_reg   <= col_d_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        s_next       = s_reg;
        line_next    = line_reg;
        col_next     = col_reg;
        wx_next      = wx_reg;
        wid_next     = wid_reg;
        wrow_next    = wrow_reg;
        valid_d_next = (state_reg == S_FETCH);
        col_d_next   = col_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    line_next  = line_y;
                    s_next     = '0;
                    state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (scan_vis) begin
                    wx_next    = slot_x[s_reg];
                    wid_next   = slot_id[s_reg];
                    wrow_next  = scan_row[3:0];
                    col_next   = '0;
                    state_next = S_FETCH;
                end else if (last_slot) begin
                    state_next = S_DONE;
                end else begin
                    s_next = s_reg + 1'b1;
                end
            end
            S_FETCH: begin
                col_next = col_reg + 1'b1;
                if (col_reg == 4'd15) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_slot) begin
                    state_next = S_DONE;
                end else begin
                    s_next     = s_reg + 1'b1;
                    state_next = S_SCAN;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ---------------- outputs ----------------
    logic [10:0] pix_sum;

    // 11-bit sum so sprites hanging off the right edge clip instead of wrapping.
    assign pix_sum = {1'b0, wx_reg} + {7'd0, col_d_reg};

    assign busy     = (state_reg != S_IDLE);
    assign done     = (state_reg == S_DONE);
    assign rom_addr = (state_reg == S_FETCH) ? {wid_reg, wrow_reg, col_reg} : 12'd0;
    assign lb_we    = valid_d_reg && (rom_pixel != 4'd0) && (pix_sum < 11'(H_ACTIVE));
    assign lb_addr  = valid_d_reg ? pix_sum[9:0] : 10'd0;
    assign lb_data  = valid_d_reg ? rom_pixel : 4'd0;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
module tb_sprite_line_fetcher;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_slot = '0;
    logic [9:0]  cfg_x = '0;
    logic [9:0]  cfg_y = '0;
    logic [3:0]  cfg_id = '0;
    logic        cfg_en = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  line_y = '0;
    logic        busy;
    logic        done;
    logic [11:0] rom_addr;
    logic [3:0]  rom_pixel = '0;
    logic        lb_we;
    logic [9:0]  lb_addr;
    logic [3:0]  lb_data;

    int total = 0;
    int bad   = 0;

    // results of the latest run_line
    int lb_mem [1024];
    int addr_log [128];
    int wcount, first_w, last_w, done_cyc, busy_gap, busy_after;

    sprite_line_fetcher #(.NSLOT(4), .H_ACTIVE(640)) dut (
        .clk(clk), .rstn(rstn),
        .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_x(cfg_x), .cfg_y(cfg_y),
        .cfg_id(cfg_id), .cfg_en(cfg_en),
        .start(start), .line_y(line_y),
        .busy(busy), .done(done),
        .rom_addr(rom_addr), .rom_pixel(rom_pixel),
        .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data)
    );

    always #5 clk = ~clk;

    // ROM contents: sprites 8..15 are solid in their own id colour;
    // sprites 0..7 use (col+row+id+9) mod 16, so sprite 3 row 4 holds col.
    function automatic logic [3:0] rom_fn(input logic [11:0] a);
        if (a[11]) return a[11:8];
        return 4'(a[3:0] + a[7:4] + a[11:8] + 4'd9);
    endfunction

    always @(posedge clk) rom_pixel <= rom_fn(rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int slot, input int x, input int y, input int id, input int en);
        @(negedge clk);
        cfg_we = 1'b1; cfg_slot = 2'(slot); cfg_x = 10'(x); cfg_y = 10'(y);
        cfg_id = 4'(id); cfg_en = en[0];
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Pulse start for line ly and watch up to 120 cycles. Cycle numbers are
    // relative to the start cycle (0). act_kind 1 pulses start again at act_k,
    // act_kind 2 rewrites slot 0 at act_k.
    task automatic run_line(input int ly, input int act_k, input int act_kind);
        for (int i = 0; i < 1024; i++) lb_mem[i] = -1;
        for (int i = 0; i < 128; i++) addr_log[i] = -1;
        wcount = 0; first_w = -1; last_w = -1; done_cyc = -1; busy_gap = 0;
        @(negedge clk);
        start = 1'b1; line_y = 10'(ly);
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            start = 1'b0; cfg_we = 1'b0;
            addr_log[k] = int'(rom_addr);
            if (!busy) busy_gap++;
            if (lb_we) begin
                lb_mem[lb_addr] = int'(lb_data);
                wcount++;
                if (first_w < 0) first_w = k;
                last_w = k;
            end
            if (done) begin
                done_cyc = k;
                break;
            end
            if (k == act_k && act_kind == 1) begin
                start = 1'b1; line_y = 10'd0;
            end
            if (k == act_k && act_kind == 2) begin
                cfg_we = 1'b1; cfg_slot = 2'd0; cfg_x = 10'd200; cfg_y = 10'd96;
                cfg_id = 4'd9; cfg_en = 1'b1;
            end
        end
        @(negedge clk);
        busy_after = int'(busy);
        $display("line %0d: done_cyc=%0d writes=%0d first_w=%0d last_w=%0d",
                 ly, done_cyc, wcount, first_w, last_w);
    endtask

    initial begin
        int done_seen;
        int busy_seen;

        // reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_lb_we", lb_we, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_lb_addr", lb_addr, 0);
        chk("rst_lb_data", lb_data, 0);
        @(negedge clk);
        rstn = 1'b1;

        // all slots disabled
        run_line(100, 0, 0);
        chk("empty_done_cyc", done_cyc, 5);
        chk("empty_writes", wcount, 0);
        chk("empty_busy_gap", busy_gap, 0);
        chk("empty_busy_after", busy_after, 0);

        // single slot, basic fetch
        cfg(0, 50, 96, 3, 1);
        run_line(100, 0, 0);
        chk("one_done_cyc", done_cyc, 22);
        chk("one_writes", wcount, 15);
        chk("one_first_w", first_w, 4);
        chk("one_last_w", last_w, 18);
        chk("one_addr_c2", addr_log[2], 32'h340);
        chk("one_addr_c17", addr_log[17], 32'h34F);
        chk("one_lb51", lb_mem[51], 1);
        chk("one_lb65", lb_mem[65], 15);
        chk("one_lb50_clear", lb_mem[50], -1);

        // vertical boundaries with y=100
        cfg(0, 50, 100, 3, 1);
        run_line(115, 0, 0);
        chk("vb115_writes", wcount, 15);
        chk("vb115_lb50", lb_mem[50], 11);
        chk("vb115_addr_c2", addr_log[2], 32'h3F0);
        run_line(116, 0, 0);
        chk("vb116_writes", wcount, 0);
        chk("vb116_done_cyc", done_cyc, 5);
        run_line(99, 0, 0);
        chk("vb99_writes", wcount, 0);
        chk("vb99_done_cyc", done_cyc, 5);

        // four overlapping slots, solid sprites 8..11
        cfg(0, 10, 96, 8, 1);
        cfg(1, 10, 96, 9, 1);
        cfg(2, 10, 96, 10, 1);
        cfg(3, 10, 96, 11, 1);
        run_line(100, 0, 0);
        chk("four_done_cyc", done_cyc, 73);
        chk("four_writes", wcount, 64);
        chk("four_lb10", lb_mem[10], 11);
        chk("four_lb25", lb_mem[25], 11);
        chk("four_lb26_clear", lb_mem[26], -1);

        // horizontal clip at the right edge
        cfg(1, 0, 0, 0, 0);
        cfg(2, 0, 0, 0, 0);
        cfg(3, 0, 0, 0, 0);
        cfg(0, 630, 96, 8, 1);
        run_line(100, 0, 0);
        chk("clip_done_cyc", done_cyc, 22);
        chk("clip_writes", wcount, 10);
        chk("clip_lb630", lb_mem[630], 8);
        chk("clip_lb639", lb_mem[639], 8);
        chk("clip_lb640_clear", lb_mem[640], -1);

        // start pulse during FETCH is ignored
        cfg(0, 50, 96, 3, 1);
        run_line(100, 5, 1);
        chk("restart_done_cyc", done_cyc, 22);
        chk("restart_writes", wcount, 15);
        chk("restart_busy_after", busy_after, 0);

        // config write to the active slot during FETCH
        cfg(0, 50, 96, 3, 1);
        run_line(100, 8, 2);
        chk("cfgmid_addr_c10", addr_log[10], 32'h348);
        chk("cfgmid_addr_c17", addr_log[17], 32'h34F);
        chk("cfgmid_lb65", lb_mem[65], 15);
        chk("cfgmid_done_cyc", done_cyc, 22);

        // reset during FETCH
        cfg(0, 50, 96, 3, 1);
        @(negedge clk);
        start = 1'b1; line_y = 10'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_pre_busy", busy, 1);
        chk("midrst_pre_lb_we", lb_we, 1);
        rstn = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_lb_we", lb_we, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        done_seen = 0;
        busy_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) done_seen++;
            if (busy) busy_seen++;
        end
        chk("midrst_no_done", done_seen, 0);
        chk("midrst_no_busy", busy_seen, 0);
        $display("reset during fetch: done_seen=%0d busy_seen=%0d", done_seen, busy_seen);

        // reset cleared the slot enables
        run_line(100, 0, 0);
        chk("postrst_writes", wcount, 0);
        chk("postrst_done_cyc", done_cyc, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_line_fetcher.md
Name: sprite_line_fetcher

Overview:
- Per-scanline sprite scheduler that owns the 4-bit sprite ROM (16 sprites of 16x16 pixels, 12-bit address).
- Holds a table of NSLOT sprite slots (x, y, sprite id, enable). On each start pulse it selects the slots that intersect the requested line.
- It sequences ROM reads for those slots and writes the non-transparent pixels into the line buffer that the video output reads on the next line.
- Sits between the game logic (slot config writes, start pulse from hblank) and the ROM and line buffer.

Parameters:
- NSLOT, 4, number of sprite slots; must be a power of 2, at least 2.
- H_ACTIVE, 640, visible pixels per line. Line-buffer writes with an address at or above H_ACTIVE are suppressed.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- cfg_we  in  1  slot table write strobe.
- cfg_slot  in  log2(NSLOT)  slot index to write.
- cfg_x  in  10  slot left edge, in pixels.
- cfg_y  in  10  slot top edge, in lines.
- cfg_id  in  4  sprite number in the ROM.
- cfg_en  in  1  slot enable.
- start  in  1  one-cycle pulse that begins fetching for line_y.
- line_y  in  10  target line. Sampled only on an accepted start.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse when the line is complete.
- rom_addr  out  12  ROM address, {id, row[3:0], col[3:0]}.
- rom_pixel  in  4  ROM data. Valid one cycle after rom_addr is presented (registered ROM).
- lb_we  out  1  line buffer write enable.
- lb_addr  out  10  line buffer pixel address.
- lb_data  out  4  pixel colour index.

Behaviour:
- Reset (rstn low, asynchronous):
  - All slot enables cleared.
  - FSM goes to IDLE.
  - busy, done, lb_we, rom_addr, lb_addr and lb_data all 0.
  - Reset asserted mid-line aborts the line immediately. No done pulse follows.
- FSM states: IDLE, SCAN, FETCH, DRAIN, DONE. Exactly one state per cycle.
- IDLE:
  - start=1 captures line_y, sets slot pointer s=0 and moves to SCAN.
  - start is ignored in every other state.
- SCAN (one cycle per slot):
  - row = line_y - y[s], modulo 2^10.
  - The slot is visible when en[s]=1 and row < 16.
  - Visible: latch x, id and row[3:0] into working registers, col=0, go to FETCH.
  - Not visible: if s is the last slot go to DONE, otherwise increment s and stay in SCAN.
- FETCH (16 cycles):
  - rom_addr = {id, row[3:0], col}. col increments every cycle.
  - Leave for DRAIN after col=15.
- Write pipeline (one-cycle delayed):
  - A valid bit and col are delayed by one cycle. In the cycle after each FETCH cycle, rom_pixel belongs to that delayed col.
  - In that cycle, lb_we = valid_d AND (rom_pixel != 0) AND (x + col_d < H_ACTIVE). The sum is computed 11 bits wide, so there is no wrap.
  - In that same cycle, lb_addr = (x + col_d)[9:0] and lb_data = rom_pixel.
  - Colour 0 is transparent and is never written.
- DRAIN (one cycle):
  - Writes the col-15 pixel.
  - Then, if s is the last slot, go to DONE. Otherwise increment s and go to SCAN.
- DONE: done=1 for one cycle, then IDLE.
- Overlap priority: slots are processed in ascending index. Higher-index slots overwrite lower ones, so the highest index is on top.
- Config writes:
  - Accepted in any state and take effect at the next clock edge.
  - The slot currently in FETCH or DRAIN uses its latched working copy and is unaffected.
  - A slot not yet scanned sees the new values.
- Latency, with start accepted at cycle 0: the SCAN of slot i occurs at cycle 1 + i + 17*(number of visible slots before i). done asserts in the cycle after the last slot's SCAN (if not visible) or DRAIN (if visible).
- Clearing the line buffer is the consumer's responsibility. This block only writes.

Test Plan:
- All slots disabled, start with line_y=100 -> SCAN at cycles 1-4, done at cycle 5, lb_we never asserted, busy high in cycles 1-5.
- Slot 0 only: x=50, y=96, id=3, en=1; line_y=100. ROM row 4 of sprite 3 has pixels 1..15 at cols 1..15 and 0 at col 0 -> rom_addr runs 0x340..0x34F in cycles 2-17. Writes occur in cycles 4-18 to lb_addr 51..65 with lb_data 1..15. No write for col 0. done at cycle 22.
- Vertical boundary, slot 0 with y=100: line_y=115 writes with row=15. line_y=116 and line_y=99 produce no writes (the latter via wrap, row=1023).
- All 4 slots visible at the same x=10 with distinct ids -> done at cycle 73. For each lb_addr, the last write comes from slot 3.
- Horizontal clip with x=630, H_ACTIVE=640 -> writes only to lb_addr 630..639. Cols 10..15 are suppressed.
- Mid-line behaviour:
  - start pulsed during FETCH is ignored, with no restart.
  - A cfg write to the active slot during FETCH leaves the rom_addr sequence unchanged.
  - rstn low during FETCH forces busy=0 and lb_we=0 immediately, and no done follows.
